// File: rtl/memory_responder_pkg.sv
// Bus types shared by the memory responder and the master side.
// Holds the FSM encoding, bus widths and the address range check.
package memory_responder_pkg;

  localparam int BUS_ADDR_W   = 32;
  localparam int BUS_DATA_W   = 32;
  localparam int BUS_STROBE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESPOND
  } responder_state_t;

  typedef struct packed {
    logic [BUS_ADDR_W-1:0]   addr;
    logic                    write;
    logic [BUS_DATA_W-1:0]   wdata;
    logic [BUS_STROBE_W-1:0] strobe;
  } bus_req_t;

  typedef struct packed {
    logic [BUS_DATA_W-1:0] rdata;
    logic                  error;
  } bus_resp_t;

  // 33-bit compare keeps the top of the address space from wrapping
  function automatic logic addr_bad(
    input logic [31:0] a,
    input logic [31:0] base,
    input logic [32:0] limit
  );
    logic [32:0] a33;
    a33 = {1'b0, a};
    return (a[1:0] != 2'b00)
        || (a33 < {1'b0, base})
        || (a33 >= limit);
  endfunction

endpackage

// File: rtl/memory_responder_if.sv
// Request/response handshake bundle between bus master and responder.
// The master drives requests; the responder drives responses.
interface memory_responder_if;
  import memory_responder_pkg::*;

  logic                    req_valid;
  logic                    req_ready;
  logic [BUS_ADDR_W-1:0]   req_addr;
  logic                    req_write;
  logic [BUS_DATA_W-1:0]   req_wdata;
  logic [BUS_STROBE_W-1:0] req_strobe;
  logic                    resp_valid;
  logic                    resp_ready;
  logic [BUS_DATA_W-1:0]   resp_rdata;
  logic                    resp_error;

  modport master (
    output req_valid, req_addr, req_write,
    output req_wdata, req_strobe, resp_ready,
    input  req_ready, resp_valid,
    input  resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_addr, req_write,
    input  req_wdata, req_strobe, resp_ready,
    output req_ready, resp_valid,
    output resp_rdata, resp_error
  );

endinterface

// File: rtl/memory_responder_memory_array.sv
// Single-port word RAM with byte write enables and registered read.
// Contents are deliberately not reset.
module memory_array #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clock,
  input  logic                           en,
  input  logic [3:0]                     we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] index,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clock) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) begin
          mem_q[index][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata_q <= mem_q[index];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/memory_responder.sv
// Single-outstanding bus slave serving an on-chip RAM after a fixed
// number of wait states.
module memory_responder
  import memory_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 1
) (
  input logic               clock,
  input logic               reset,
  memory_responder_if.slave bus
);

  localparam int IW = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT =
    {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);
  localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  responder_state_t state_q;
  logic [3:0]       cnt_q;
  bus_req_t         req_q;
  logic             req_ready_q;
  logic             resp_valid_q;
  logic             resp_error_q;
  logic             rd_q;

  bus_req_t    live_req;
  bus_req_t    cur_req;
  logic        accept;
  logic        access;
  logic        err;
  logic [3:0]  ram_we;
  logic [IW-1:0] ram_idx;
  logic [31:0] ram_rdata;

  // In IDLE the live bus is the request; afterwards the latched copy
  always_comb begin
    live_req.addr   = bus.req_addr;
    live_req.write  = bus.req_write;
    live_req.wdata  = bus.req_wdata;
    live_req.strobe = bus.req_strobe;
    cur_req = (state_q == IDLE) ? live_req : req_q;
  end

  assign accept = bus.req_valid & req_ready_q;
  assign access = reset & (
    (accept & ZERO_WAIT) |
    ((state_q == WAIT) & (cnt_q == 4'd0)));
  assign err     = addr_bad(cur_req.addr, BASE_ADDR, LIMIT);
  assign ram_we  = (cur_req.write & ~err) ? cur_req.strobe : 4'b0000;
  assign ram_idx = IW'((cur_req.addr - BASE_ADDR) >> 2);

  memory_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_mem (
    .clock(clock),
    .en   (access),
    .we   (ram_we),
    .index(ram_idx),
    .wdata(cur_req.wdata),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      req_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      rd_q         <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            req_q       <= live_req;
            req_ready_q <= 1'b0;
            cnt_q       <= CNT_LOAD;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESPOND: begin
          if (bus.resp_ready) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            rd_q         <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (access) begin
        state_q      <= RESPOND;
        resp_valid_q <= 1'b1;
        resp_error_q <= err;
        rd_q         <= ~cur_req.write & ~err;
      end
    end
  end

  // RAM read register holds still until the next access
  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_error = resp_error_q;
  assign bus.resp_rdata = rd_q ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder with one and zero wait states.
// Each task drives a scenario and checks its own results.
module tb_memory_responder;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  memory_responder_if b1 ();
  memory_responder_if b0 ();

  memory_responder #(
    .BASE_ADDR  (32'h0000_0000),
    .DEPTH_WORDS(1024),
    .WAIT_CYCLES(1)
  ) dut1 (
    .clock(clock),
    .reset(reset),
    .bus  (b1)
  );

  memory_responder #(
    .BASE_ADDR  (32'h0000_0000),
    .DEPTH_WORDS(1024),
    .WAIT_CYCLES(0)
  ) dut0 (
    .clock(clock),
    .reset(reset),
    .bus  (b0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic xact1(
    input  logic [31:0] a,
    input  logic        w,
    input  logic [31:0] d,
    input  logic [3:0]  s,
    output logic [31:0] rd,
    output logic        er,
    output int          lat
  );
    int n;
    @(negedge clock);
    b1.req_addr   = a;
    b1.req_write  = w;
    b1.req_wdata  = d;
    b1.req_strobe = s;
    b1.req_valid  = 1'b1;
    b1.resp_ready = 1'b1;
    n = 0;
    while (!b1.req_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    @(posedge clock);
    @(negedge clock);
    b1.req_valid = 1'b0;
    lat = 1;
    while (!b1.resp_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    rd = b1.resp_rdata;
    er = b1.resp_error;
    @(posedge clock);
    @(negedge clock);
    b1.resp_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #12;
    total++;
    if (b1.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_req_ready got=%b want=1", b1.req_ready);
    end
    total++;
    if (b1.resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_resp_valid got=%b want=0", b1.resp_valid);
    end
    total++;
    if (b1.resp_rdata !== 32'h0) begin
      bad++;
      $display("FAIL rst_rdata got=%h want=0", b1.resp_rdata);
    end
    total++;
    if (b1.resp_error !== 1'b0) begin
      bad++;
      $display("FAIL rst_error got=%b want=0", b1.resp_error);
    end
    total++;
    if (b0.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst0_req_ready got=%b want=1", b0.req_ready);
    end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_write_read;
    logic [31:0] rd;
    logic er;
    int lat;
    xact1(32'h10, 1'b1, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
    total++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      bad++;
      $display("FAIL wr_resp got=%h/%b want=0/0", rd, er);
    end
    total++;
    if (lat !== 2) begin
      bad++;
      $display("FAIL wr_latency got=%0d want=2", lat);
    end
    xact1(32'h10, 1'b0, 32'h0, 4'h0, rd, er, lat);
    total++;
    if (rd !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL rd_data got=%h want=deadbeef", rd);
    end
    total++;
    if (er !== 1'b0) begin
      bad++;
      $display("FAIL rd_error got=%b want=0", er);
    end
    total++;
    if (lat !== 2) begin
      bad++;
      $display("FAIL rd_latency got=%0d want=2", lat);
    end
  endtask

  task automatic test_strobes;
    logic [31:0] rd;
    logic er;
    int lat;
    xact1(32'h20, 1'b1, 32'h1122_3344, 4'hF, rd, er, lat);
    xact1(32'h20, 1'b1, 32'hAABB_CCDD, 4'h5, rd, er, lat);
    xact1(32'h20, 1'b0, 32'h0, 4'h0, rd, er, lat);
    total++;
    if (rd !== 32'h11BB_33DD) begin
      bad++;
      $display("FAIL strobe_merge got=%h want=11bb33dd", rd);
    end
    xact1(32'h20, 1'b1, 32'hFFFF_FFFF, 4'h0, rd, er, lat);
    total++;
    if (er !== 1'b0) begin
      bad++;
      $display("FAIL strobe0_error got=%b want=0", er);
    end
    xact1(32'h20, 1'b0, 32'h0, 4'hF, rd, er, lat);
    total++;
    if (rd !== 32'h11BB_33DD) begin
      bad++;
      $display("FAIL strobe0_keep got=%h want=11bb33dd", rd);
    end
  endtask

  task automatic test_errors;
    logic [31:0] rd;
    logic er;
    int lat;
    xact1(32'h22, 1'b0, 32'h0, 4'hF, rd, er, lat);
    total++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      bad++;
      $display("FAIL err_misalign got=%h/%b want=0/1", rd, er);
    end
    xact1(32'h1000, 1'b0, 32'h0, 4'hF, rd, er, lat);
    total++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      bad++;
      $display("FAIL err_top got=%h/%b want=0/1", rd, er);
    end
    xact1(32'hFFFF_FFFC, 1'b0, 32'h0, 4'hF, rd, er, lat);
    total++;
    if (er !== 1'b1) begin
      bad++;
      $display("FAIL err_wrap got=%b want=1", er);
    end
    xact1(32'h0FFC, 1'b0, 32'h0, 4'hF, rd, er, lat);
    total++;
    if (er !== 1'b0) begin
      bad++;
      $display("FAIL err_last_word got=%b want=0", er);
    end
    xact1(32'h22, 1'b1, 32'h0, 4'hF, rd, er, lat);
    total++;
    if (er !== 1'b1) begin
      bad++;
      $display("FAIL err_wr_misalign got=%b want=1", er);
    end
    xact1(32'h20, 1'b0, 32'h0, 4'hF, rd, er, lat);
    total++;
    if (rd !== 32'h11BB_33DD || er !== 1'b0) begin
      bad++;
      $display("FAIL err_untouched got=%h/%b want=11bb33dd/0", rd, er);
    end
  endtask

  task automatic test_backpressure;
    int n;
    @(negedge clock);
    b1.req_addr   = 32'h10;
    b1.req_write  = 1'b0;
    b1.req_wdata  = 32'h0;
    b1.req_strobe = 4'h0;
    b1.req_valid  = 1'b1;
    b1.resp_ready = 1'b0;
    @(posedge clock);
    @(negedge clock);
    b1.req_valid = 1'b0;
    b1.req_addr  = 32'h20;
    n = 0;
    while (!b1.resp_valid && n < 10) begin
      @(negedge clock);
      n++;
    end
    total++;
    if (n >= 10) begin
      bad++;
      $display("FAIL bp_valid_timeout got=%0d want<10", n);
    end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (b1.resp_valid !== 1'b1 || b1.req_ready !== 1'b0 ||
          b1.resp_rdata !== 32'hDEAD_BEEF ||
          b1.resp_error !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold%0d got=%b/%b/%h/%b want=1/0/deadbeef/0",
                 i, b1.resp_valid, b1.req_ready,
                 b1.resp_rdata, b1.resp_error);
      end
      @(negedge clock);
    end
    b1.resp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    b1.resp_ready = 1'b0;
    total++;
    if (b1.resp_valid !== 1'b0 || b1.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release got=%b/%b want=0/1",
               b1.resp_valid, b1.req_ready);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_d [8];
    int acc [8];
    int k;
    int r;
    int cyc;
    for (int i = 0; i < 4; i++) begin
      exp_d[i]   = 32'h0;
      exp_d[i+4] = 32'hC0DE_0000 | i;
    end
    k = 0;
    r = 0;
    b0.resp_ready = 1'b1;
    for (cyc = 0; cyc < 60 && r < 8; cyc++) begin
      @(negedge clock);
      if (b0.resp_valid) begin
        total++;
        if (b0.resp_rdata !== exp_d[r] || b0.resp_error !== 1'b0 ||
            cyc !== acc[r] + 1) begin
          bad++;
          $display("FAIL b2b_resp%0d got=%h/%b@%0d want=%h/0@%0d",
                   r, b0.resp_rdata, b0.resp_error, cyc,
                   exp_d[r], acc[r] + 1);
        end
        r++;
      end
      if (b0.req_ready && k < 8) begin
        acc[k] = cyc;
        b0.req_valid  = 1'b1;
        b0.req_write  = (k < 4);
        b0.req_addr   = 32'h40 + 32'(4 * (k % 4));
        b0.req_wdata  = 32'hC0DE_0000 | 32'(k % 4);
        b0.req_strobe = 4'hF;
        k++;
      end else if (b0.req_ready) begin
        b0.req_valid = 1'b0;
      end
    end
    b0.req_valid  = 1'b0;
    b0.resp_ready = 1'b0;
    total++;
    if (r !== 8) begin
      bad++;
      $display("FAIL b2b_count got=%0d want=8", r);
    end
    for (int i = 1; i < 8; i++) begin
      total++;
      if (acc[i] - acc[i-1] !== 2) begin
        bad++;
        $display("FAIL b2b_spacing%0d got=%0d want=2",
                 i, acc[i] - acc[i-1]);
      end
    end
  endtask

  task automatic test_mid_reset;
    logic [31:0] rd;
    logic er;
    int lat;
    xact1(32'h30, 1'b1, 32'h0, 4'hF, rd, er, lat);
    @(negedge clock);
    b1.req_addr   = 32'h30;
    b1.req_write  = 1'b1;
    b1.req_wdata  = 32'hFFFF_FFFF;
    b1.req_strobe = 4'hF;
    b1.req_valid  = 1'b1;
    b1.resp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    b1.req_valid = 1'b0;
    total++;
    if (b1.req_ready !== 1'b0) begin
      bad++;
      $display("FAIL mr_in_wait got=%b want=0", b1.req_ready);
    end
    reset = 1'b0;
    #1;
    total++;
    if (b1.req_ready !== 1'b1 || b1.resp_valid !== 1'b0 ||
        b1.resp_rdata !== 32'h0 || b1.resp_error !== 1'b0) begin
      bad++;
      $display("FAIL mr_outputs got=%b/%b/%h/%b want=1/0/0/0",
               b1.req_ready, b1.resp_valid,
               b1.resp_rdata, b1.resp_error);
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    b1.resp_ready = 1'b0;
    xact1(32'h30, 1'b0, 32'h0, 4'hF, rd, er, lat);
    total++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      bad++;
      $display("FAIL mr_no_commit got=%h/%b want=0/0", rd, er);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    b1.req_valid  = 1'b0;
    b1.req_addr   = 32'h0;
    b1.req_write  = 1'b0;
    b1.req_wdata  = 32'h0;
    b1.req_strobe = 4'h0;
    b1.resp_ready = 1'b0;
    b0.req_valid  = 1'b0;
    b0.req_addr   = 32'h0;
    b0.req_write  = 1'b0;
    b0.req_wdata  = 32'h0;
    b0.req_strobe = 4'h0;
    b0.resp_ready = 1'b0;
    test_reset();
    test_write_read();
    test_strobes();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
